// File: rtl/t09_tft_pkg.sv
// t09_tft_pkg: opcodes and receiver state type shared by the TFT bus receiver files
package t09_tft_pkg;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  typedef enum logic [2:0] {IDLE, CASET, PASET, RAM_HI, RAM_LO} tft_rx_state_t;
endpackage

// File: rtl/t09_tft_rx_edge.sv
// t09_tft_rx_edge: optional bus synchronizer plus wr rising-edge strobe
// Ports: clk, nrst (async active-low), en, wr/dcx/d (raw bus) -> stb, dcx_s, d_s (bus as seen at stb).
// Macro T09_TFT_RX_SYNC_EN adds a 2-flop synchronizer on wr, dcx and d.
module t09_tft_rx_edge (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       wr,
  input  logic       dcx,
  input  logic [7:0] d,
  output logic       stb,
  output logic       dcx_s,
  output logic [7:0] d_s
);
  logic wr_s, wr_q;
`ifdef T09_TFT_RX_SYNC_EN
  logic [9:0] s1, s2;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {wr, dcx, d};
      s2 <= s1;
    end
  assign {wr_s, dcx_s, d_s} = s2;
`else
  assign {wr_s, dcx_s, d_s} = {wr, dcx, d};
`endif
  // wr_q tracks wr even while disabled so re-enabling mid-pulse gives no false edge
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) wr_q <= 1'b0;
    else wr_q <= wr_s;
  assign stb = en & wr_s & ~wr_q;
endmodule

// File: rtl/t09_tft_bus_receiver.sv
// t09_tft_bus_receiver: decodes the 8080 TFT write bus into commands and (x, y, RGB565) pixels
// Ports: clk, nrst (async active-low), en, wr, dcx, d[7:0] in;
//   cmd_valid/cmd_byte, pix_valid/pix_x/pix_y/pix_rgb, frame_done, busy out (all registered).
// Macro T09_TFT_RX_SYNC_EN synchronizes the bus inputs (latency 3 instead of 1).
module t09_tft_bus_receiver
  import t09_tft_pkg::*;
#(
  parameter int X_W    = 9,
  parameter int Y_W    = 9,
  parameter int DEF_EC = 319,
  parameter int DEF_EP = 239
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           en,
  input  logic           wr,
  input  logic           dcx,
  input  logic [7:0]     d,
  output logic           cmd_valid,
  output logic [7:0]     cmd_byte,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [15:0]    pix_rgb,
  output logic           frame_done,
  output logic           busy
);
  tft_rx_state_t  state;
  logic [1:0]     pi;
  logic [X_W-1:0] sc, ec, cx;
  logic [Y_W-1:0] sp, ep, cy;
  logic [7:0]     s_hi, s_lo, e_hi, hi;
  logic           stb, dcx_s;
  logic [7:0]     d_s;

  t09_tft_rx_edge u_edge (
    .clk(clk), .nrst(nrst), .en(en), .wr(wr), .dcx(dcx), .d(d),
    .stb(stb), .dcx_s(dcx_s), .d_s(d_s)
  );

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state      <= IDLE;
      pi         <= '0;
      busy       <= 1'b0;
      sc         <= '0;
      ec         <= X_W'(DEF_EC);
      sp         <= '0;
      ep         <= Y_W'(DEF_EP);
      cx         <= '0;
      cy         <= '0;
      s_hi       <= '0;
      s_lo       <= '0;
      e_hi       <= '0;
      hi         <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (stb && !dcx_s) begin
        // a command always wins: staged window bytes and half pixels are simply abandoned
        cmd_valid <= 1'b1;
        cmd_byte  <= d_s;
        pi        <= '0;
        state     <= d_s == CMD_CASET ? CASET : d_s == CMD_PASET ? PASET :
                     d_s == CMD_RAMWR ? RAM_HI : IDLE;
        busy      <= d_s == CMD_CASET || d_s == CMD_PASET || d_s == CMD_RAMWR;
        if (d_s == CMD_RAMWR) begin
          cx <= sc;
          cy <= sp;
        end
        if (d_s == CMD_SWRESET) begin
          sc <= '0;
          ec <= X_W'(DEF_EC);
          sp <= '0;
          ep <= Y_W'(DEF_EP);
        end
      end else if (stb) begin
        case (state)
          CASET, PASET: begin
            pi <= pi + 2'd1;
            if (pi == 2'd0) s_hi <= d_s;
            if (pi == 2'd1) s_lo <= d_s;
            if (pi == 2'd2) e_hi <= d_s;
            if (pi == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (state == CASET) begin
                sc <= X_W'({s_hi, s_lo});
                ec <= X_W'({e_hi, d_s});
              end else begin
                sp <= Y_W'({s_hi, s_lo});
                ep <= Y_W'({e_hi, d_s});
              end
            end
          end
          RAM_HI: begin
            hi    <= d_s;
            state <= RAM_LO;
          end
          RAM_LO: begin
            pix_valid <= 1'b1;
            pix_x     <= cx;
            pix_y     <= cy;
            pix_rgb   <= {hi, d_s};
            state     <= RAM_HI;
            // >= rather than == so a degenerate window (start > end) pins to the start
            if (cx >= ec) begin
              cx <= sc;
              if (cy >= ep) begin
                cy         <= sp;
                frame_done <= 1'b1;
              end else cy <= cy + Y_W'(1);
            end else cx <= cx + X_W'(1);
          end
          default: ;
        endcase
      end
    end
endmodule
